// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start/data/parity/stop recovery with 3-sample majority vote,
// valid/ready word output, per-word parity/framing/break flags and a sticky overrun flag.
`timescale 1ns/1ps
module uart_rx_engine #(
    parameter int unsigned DATA_BITS_MAX = 9,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DIV_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     uart_en,
    input  logic                     rx_en,
    input  logic [DIV_WIDTH-1:0]     baud_div,
    input  logic [3:0]               data_len,
    input  logic [1:0]               parity_mode,
    input  logic                     stop_bits,
    input  logic                     rx_bit,
    output logic [DATA_BITS_MAX-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     parity_error,
    output logic                     frame_error,
    output logic                     break_detect,
    output logic                     overrun_error,
    input  logic                     err_clear,
    output logic                     busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE / 2);
    localparam logic [TickW-1:0] TickVote = TickW'(OVERSAMPLE / 2 + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle, StHunt, StStart, StData, StParity, StStop, StStop2
    } state_e;

    state_e                   state_q, state_d;
    logic                     meta_q, rxs_q;
    logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
    logic [TickW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [1:0]               samp_q, samp_d;
    logic [DATA_BITS_MAX-1:0] shift_q, shift_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [3:0]               len_q, len_d;
    logic                     par_en_q, par_en_d;
    logic                     par_odd_q, par_odd_d;
    logic                     two_stop_q, two_stop_d;
    logic                     par_bit_q, par_bit_d;
    logic                     par_err_q, par_err_d;
    logic                     frm_err_q, frm_err_d;
    logic                     wait_high_q, wait_high_d;
    logic [DATA_BITS_MAX-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     pe_q, pe_d;
    logic                     fe_q, fe_d;
    logic                     bd_q, bd_d;
    logic                     ovr_q, ovr_d;

    logic [DIV_WIDTH-1:0] div_load;
    logic [3:0]           len_clamp;
    logic                 running, tick, vote_now, bit_end, voted, start_hit;
    logic                 commit, fe_now, bd_now;

    always_comb begin
        div_load  = ((baud_div == '0) ? DIV_WIDTH'(1) : baud_div) - DIV_WIDTH'(1);
        len_clamp = (data_len < 4'd5) ? 4'd5 :
                    (data_len > 4'(DATA_BITS_MAX)) ? 4'(DATA_BITS_MAX) : data_len;
        running   = (state_q != StIdle) && (state_q != StHunt);
        tick      = running && (div_cnt_q == '0);
        vote_now  = tick && (tick_cnt_q == TickVote);
        bit_end   = tick && (tick_cnt_q == TickLast);
        voted     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
        // A break holds the line low past the stop bit; don't re-arm until it returns high.
        start_hit = (state_q == StHunt) && uart_en && rx_en && !rxs_q && !wait_high_q;
        fe_now    = frm_err_q | ~voted;
        bd_now    = (shift_q == '0) && (!par_en_q || !par_bit_q) && fe_now;
        busy      = running;
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        commit     = 1'b0;

        if (start_hit) begin
            div_cnt_d = div_load;
        end else if (running) begin
            div_cnt_d = tick ? div_load : div_cnt_q - DIV_WIDTH'(1);
        end

        if (tick) begin
            tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
            if (tick_cnt_q == TickS0) samp_d[0] = rxs_q;
            if (tick_cnt_q == TickS1) samp_d[1] = rxs_q;
        end

        unique case (state_q)
            StIdle: begin
                if (uart_en) state_d = StHunt;
            end
            StHunt: begin
                if (start_hit) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    len_d      = len_clamp;
                    par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d  = (parity_mode == 2'b10);
                    two_stop_d = stop_bits;
                    par_bit_d  = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            StStart: begin
                if (vote_now && voted) state_d = StHunt;
                else if (bit_end)      state_d = StData;
            end
            StData: begin
                if (vote_now) begin
                    for (int unsigned i = 0; i < DATA_BITS_MAX; i++) begin
                        if (4'(i) == bit_cnt_q) shift_d[i] = voted;
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (bit_end && (bit_cnt_q == len_q)) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (vote_now) begin
                    par_bit_d = voted;
                    par_err_d = voted != ((^shift_q) ^ par_odd_q);
                end
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (vote_now) begin
                    frm_err_d = fe_now;
                    if (!two_stop_q) begin
                        commit  = 1'b1;
                        state_d = StHunt;
                    end
                end else if (bit_end) begin
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (vote_now) begin
                    frm_err_d = fe_now;
                    commit    = 1'b1;
                    state_d   = StHunt;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!uart_en) begin
            state_d = StIdle;
            commit  = 1'b0;
        end
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        pe_d        = pe_q;
        fe_d        = fe_q;
        bd_d        = bd_q;
        ovr_d       = ovr_q;
        wait_high_d = wait_high_q;

        if (commit && !voted) wait_high_d = 1'b1;
        else if (rxs_q)       wait_high_d = 1'b0;

        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                pe_d    = par_err_q;
                fe_d    = fe_now;
                bd_d    = bd_now;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (err_clear && !(commit && valid_q && !rx_ready)) ovr_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            samp_q      <= 2'b11;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            len_q       <= 4'd5;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            wait_high_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            bd_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= rx_bit;
            rxs_q       <= meta_q;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            two_stop_q  <= two_stop_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            wait_high_q <= wait_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            pe_q        <= pe_d;
            fe_q        <= fe_d;
            bd_q        <= bd_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = pe_q;
    assign frame_error   = fe_q;
    assign break_detect  = bd_q;
    assign overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomised bench for uart_rx_engine: a frame-level model pushes expected words into a
// scoreboard and an independent monitor pops and compares on every accepted word.
`timescale 1ns/1ps
module tb_uart_rx_engine;

    localparam int OS = 16;

    logic        clock = 1'b0;
    logic        reset, uart_en, rx_en, stop_bits, rx_bit, rx_ready, err_clear;
    logic [15:0] baud_div;
    logic [3:0]  data_len;
    logic [1:0]  parity_mode;
    logic [8:0]  rx_data;
    logic        rx_valid, parity_error, frame_error, break_detect, overrun_error, busy;

    uart_rx_engine #(.DATA_BITS_MAX(9), .OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_en       (uart_en),
        .rx_en         (rx_en),
        .baud_div      (baud_div),
        .data_len      (data_len),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .rx_bit        (rx_bit),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .break_detect  (break_detect),
        .overrun_error (overrun_error),
        .err_clear     (err_clear),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] data;
        logic       pe, fe, bd;
        int         max_lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected frame.
    exp_t m;
    always @(negedge clock) begin
        if (!reset && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", rx_data);
            end else begin
                m = sb.pop_front();
                chk("rx_data", 32'(rx_data), 32'(m.data));
                chk("parity_error", 32'(parity_error), 32'(m.pe));
                chk("frame_error", 32'(frame_error), 32'(m.fe));
                chk("break_detect", 32'(break_detect), 32'(m.bd));
                if (m.max_lat > 0) begin
                    checks++;
                    if (cyc - m.t0 > m.max_lat) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected <= %0d",
                                 cyc - m.t0, m.max_lat);
                    end
                end
            end
        end
    end

    function automatic int bp();
        return OS * ((baud_div == 16'd0) ? 1 : int'(baud_div));
    endfunction

    // Drive one bit period, optionally inverting the line for one cycle at mid-bit.
    task automatic drive_bit(input logic b, input bit spike);
        int p;
        p = bp();
        rx_bit = b;
        repeat (p / 2) @(negedge clock);
        if (spike) rx_bit = ~b;
        @(negedge clock);
        rx_bit = b;
        repeat (p - p / 2 - 1) @(negedge clock);
    endtask

    task automatic send(input logic [8:0] d, input logic [3:0] dl, input logic [1:0] pm,
                        input logic two, input logic par_val, input logic st1,
                        input logic st2, input int spike, input bit push, input int lat);
        int         len;
        logic       pen, exp_par;
        logic [8:0] dm;
        exp_t       e;
        len     = (dl < 4'd5) ? 5 : ((dl > 4'd9) ? 9 : int'(dl));
        pen     = (pm == 2'b01) || (pm == 2'b10);
        dm      = d & ((9'd1 << len) - 9'd1);
        exp_par = (($countones(dm) % 2) == 1) ^ (pm == 2'b10);
        @(negedge clock);
        data_len    = dl;
        parity_mode = pm;
        stop_bits   = two;
        e.data    = dm;
        e.pe      = pen && (par_val != exp_par);
        e.fe      = !st1 || (two && !st2);
        e.bd      = (dm == 9'd0) && (!pen || !par_val) && e.fe;
        e.max_lat = lat;
        e.t0      = cyc;
        if (push) sb.push_back(e);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < len; i++) drive_bit(dm[i], spike == i);
        if (pen) drive_bit(par_val, 1'b0);
        drive_bit(st1, 1'b0);
        if (two) drive_bit(st2, 1'b0);
        rx_bit = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx_bit = 1'b1;
        repeat (n * bp()) @(negedge clock);
    endtask

    initial begin
        logic [3:0] rdl;
        logic [1:0] rpm;
        logic       rtwo, rpar, rs1, rs2;
        logic [8:0] rd;
        int         len, drain;

        reset = 1'b1; uart_en = 1'b0; rx_en = 1'b0; rx_bit = 1'b1; rx_ready = 1'b1;
        err_clear = 1'b0; baud_div = 16'd1; data_len = 4'd8; parity_mode = 2'b00;
        stop_bits = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_flags", 32'({parity_error, frame_error, break_detect, overrun_error}), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0; uart_en = 1'b1; rx_en = 1'b1;
        idle_bits(1);

        // 8N1 0xA5 with a latency bound of 16*9.5+5 cycles.
        send(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1, 157);
        idle_bits(2);

        // 7E2 0x55: bad parity then good parity.
        send(9'h055, 4'd7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 0);
        idle_bits(2);
        send(9'h055, 4'd7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b1, 0);
        idle_bits(2);

        // False start from a 3-cycle glitch, then a frame with a 1-cycle mid-bit spike.
        data_len = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
        @(negedge clock);
        rx_bit = 1'b0;
        repeat (3) @(negedge clock);
        rx_bit = 1'b1;
        repeat (3) @(negedge clock);
        chk("glitch_enters_start", 32'(busy), 32'h1);
        repeat (30) @(negedge clock);
        chk("glitch_back_to_hunt", 32'(busy), 32'h0);
        send(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 0);
        idle_bits(2);

        // uart_en dropped for one cycle mid-DATA discards the frame.
        fork
            send(9'h0FF, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
            begin
                repeat (3 * OS + 6) @(negedge clock);
                chk("en_drop_midframe_busy", 32'(busy), 32'h1);
                uart_en = 1'b0;
                @(negedge clock);
                chk("en_drop_idle", 32'(busy), 32'h0);
                uart_en = 1'b1;
            end
        join
        idle_bits(2);
        chk("en_drop_no_valid", 32'(rx_valid), 32'h0);

        // Reset mid-frame zeroes all outputs.
        fork
            send(9'h0FF, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
            begin
                repeat (3 * OS + 6) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                chk("midreset_outputs",
                    32'({rx_data, rx_valid, parity_error, frame_error, break_detect,
                         overrun_error, busy}), 32'h0);
                reset = 1'b0;
            end
        join
        idle_bits(2);

        // 9O1 0x1FF with correct parity.
        send(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1, 0);
        idle_bits(2);

        // Overrun: consumer stalled across two back-to-back words.
        rx_ready = 1'b0;
        send(9'h011, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1, 0);
        send(9'h022, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
        @(negedge clock);
        chk("overrun_set", 32'(overrun_error), 32'h1);
        chk("overrun_held_data", 32'(rx_data), 32'h011);
        chk("overrun_held_valid", 32'(rx_valid), 32'h1);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        chk("overrun_cleared", 32'(overrun_error), 32'h0);
        rx_ready = 1'b1;
        idle_bits(1);

        // Break: line low for 12 bit periods yields one word only.
        data_len = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0;
        @(negedge clock);
        sb.push_back('{data: 9'h0, pe: 1'b0, fe: 1'b1, bd: 1'b1, max_lat: 0, t0: cyc});
        rx_bit = 1'b0;
        repeat (12 * bp()) @(negedge clock);
        rx_bit = 1'b1;
        idle_bits(2);
        chk("break_single_word", 32'(sb.size()), 32'h0);

        // Randomised frame formats, divisors and line errors.
        for (int n = 0; n < 40; n++) begin
            baud_div = 16'($urandom_range(0, 3));
            rdl  = 4'($urandom_range(0, 15));
            rpm  = 2'($urandom_range(0, 3));
            rtwo = 1'($urandom_range(0, 1));
            rd   = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
            len  = (rdl < 4'd5) ? 5 : ((rdl > 4'd9) ? 9 : int'(rdl));
            rpar = (($countones(rd & ((9'd1 << len) - 9'd1)) % 2) == 1) ^ (rpm == 2'b10);
            if ($urandom_range(0, 3) == 0) rpar = ~rpar;
            rs1  = ($urandom_range(0, 5) != 0);
            rs2  = ($urandom_range(0, 5) != 0);
            send(rd, rdl, rpm, rtwo, rpar, rs1, rs2, -1, 1'b1, 0);
            idle_bits(2);
        end

        drain = 0;
        while (sb.size() != 0 && drain < 2000) begin
            @(negedge clock);
            drain++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receive engine: the next generation of the receive half of the UART controller. It recovers serial frames from the line with an internal oversampling baud generator and 3-sample majority voting. Frame format is configurable at run time: 5..DATA_BITS_MAX data bits, none/even/odd parity, 1 or 2 stop bits. Each received word is presented on a valid/ready port that feeds the RX FIFO write side, with per-word parity, framing and break flags and a sticky overrun flag.

## Interface
- DATA_BITS_MAX, 9: width of `rx_data`; legal range 5..9.
- OVERSAMPLE, 16: ticks per bit; even value, minimum 8.
- DIV_WIDTH, 16: width of `baud_div`.
- clock  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_en  input  1  global enable; deassertion aborts any frame.
- rx_en  input  1  receiver enable; gates new start-bit detection only.
- baud_div  input  DIV_WIDTH  clock cycles per oversample tick; 0 is treated as 1.
- data_len  input  4  data bits per frame; values below 5 are treated as 5, values above DATA_BITS_MAX as DATA_BITS_MAX.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- rx_bit  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS_MAX  received word, LSB first on the line, right-aligned, unused MSBs 0.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts the word (FIFO not full).
- parity_error  output  1  parity mismatch for the presented word.
- frame_error  output  1  a stop bit was sampled 0 for the presented word.
- break_detect  output  1  presented word is all-zero, parity (if enabled) is 0, and frame_error is set.
- overrun_error  output  1  sticky; a word was lost.
- err_clear  input  1  clears overrun_error.
- busy  output  1  high in every state except IDLE and HUNT.

## Operation
- `rx_bit` passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value `rxs`.
- Tick generator: a down-counter loads `baud_div-1` and emits a 1-cycle `tick` on reaching 0. It runs only outside IDLE and restarts on the HUNT→START transition.
- Majority sample: `rxs` is captured on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit period. The bit value is the 2-of-3 majority and is valid after tick OVERSAMPLE/2+1. A per-bit tick counter runs 0..OVERSAMPLE-1 and wraps.
- `data_len`, `parity_mode` and `stop_bits` are latched on the HUNT→START transition. Changes mid-frame have no effect on the current frame.
- States:
  - IDLE: leave to HUNT when `uart_en`.
  - HUNT: go to START when `rx_en` and `rxs` is 0; go to IDLE when `!uart_en`.
  - START: at the voted sample, a 1 is a false start and returns to HUNT with no flags. A 0 continues; at tick OVERSAMPLE-1 go to DATA.
  - DATA: shift the voted bit into bit [count] of the shift register. After `data_len` bits, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: expected value is the XOR of the data bits for even, its complement for odd. Mismatch sets the parity flag for this word.
  - STOP: a voted 0 sets frame_err. With `stop_bits`=1, STOP2 follows and applies the same check, OR-ed.
  - On the voted sample of the final stop bit: commit the word, then go to HUNT immediately (mid-stop-bit), so back-to-back frames are caught.
- `uart_en` low in any state goes to IDLE next cycle: frame discarded, no flags, output register untouched.
- `rx_en` low mid-frame has no effect; the frame completes.
- Commit:
  - If `rx_valid` is 0, or `rx_valid && rx_ready` in the same cycle: load `rx_data`, the per-word flags and `rx_valid`=1.
  - Otherwise the new word is dropped, `overrun_error` is set, and the held word and its flags are unchanged.
- Handshake: `rx_valid` falls the cycle after `rx_valid && rx_ready`. `rx_data` and the flags are stable while `rx_valid` is 1.
- `overrun_error` is cleared by `err_clear`. If set and clear coincide in the same cycle, set wins.

## Timing
- Reset values: `rx_data` 0, `rx_valid` 0, all error flags 0, `busy` 0; state IDLE.
- One bit period = OVERSAMPLE×max(baud_div,1) clock cycles.
- Latency: the line falling edge reaches START after 2 synchroniser cycles plus 1 state cycle.
- `rx_valid` rises 1 cycle after the tick that completes the final stop-bit vote.
- Flags change only in the same cycle `rx_valid` is loaded. `overrun_error` changes only on a dropped commit or on clear.
- Tolerates ±(OVERSAMPLE/2-2)/OVERSAMPLE of a bit period of cumulative drift at the last stop bit.

## Test plan
- baud_div=1, 8N1 (data_len=8, parity_mode=00, stop_bits=0), send 0xA5 → `rx_data`=0x0A5, all flags 0, `rx_valid` high ≤ 16×9.5+5 cycles after the start edge.
- 7E2 (data_len=7, parity 01, stop_bits=1), send 0x55 with parity bit 1 → `parity_error`=1, `rx_data`=0x055; repeat with parity 0 → `parity_error`=0.
- 8N1, drive a 3-cycle low glitch on an idle line → false start: no `rx_valid`, engine back in HUNT. Then send 0x3C with a 1-cycle spike mid-bit → `rx_data`=0x03C, flags 0.
- Hold `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data`=0x011 held, `overrun_error`=1. Pulse `err_clear` → `overrun_error`=0.
- Hold the line low for 12 bit periods with 8N1 → `rx_data`=0, `frame_error`=1, `break_detect`=1; no further word until the line has gone high then low again.
- Mid-DATA drop `uart_en` for 1 cycle, and separately assert `reset` mid-frame → state IDLE, no `rx_valid`; reset also zeroes all outputs. The next frame, 9O1 0x1FF, is received correctly.
